pc_sequencer: RTL

- Run-control and next-PC controller for the core's synchronous program counter.
- Drives the PC register's enable, load and load-address inputs.
- Arbitrates redirect sources (exception, taken branch, jump) and honours pipeline stalls.
- Implements run/halt/single-step control for the debug host and the syscall-halt path; counts PC advances.

---
 rtl/pc_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Run-control and next-PC controller: redirect arbitration, stall handling, run/halt/step.
// Optional breakpoint unit enabled by defining PC_SEQUENCER_BREAKPOINT_EN.
module pc_sequencer #(
  parameter int unsigned            ADDR_W     = 10,
  parameter logic [ADDR_W-1:0]      EXC_VECTOR = '0,
  parameter bit                     AUTO_RUN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              sys_halt,
  input  logic              stall,
  input  logic              exc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic [ADDR_W-1:0] pc,
`ifdef PC_SEQUENCER_BREAKPOINT_EN
  input  logic              bp_valid,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit,
`endif
  output logic              pc_en,
  output logic              pc_ld,
  output logic [ADDR_W-1:0] pc_new,
  output logic              flush,
  output logic              running,
  output logic              halted,
  output logic [31:0]       adv_cnt
);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_t;
  localparam state_t S_RESET = AUTO_RUN ? S_RUN : S_HALT;

  state_t r_state, w_next;
  logic   w_go, w_bp;

`ifdef PC_SEQUENCER_BREAKPOINT_EN
  logic r_skip;
  assign w_bp   = (r_state == S_RUN) && bp_valid && (pc == bp_addr) && !r_skip;
  assign bp_hit = w_bp;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
  assign w_bp        = 1'b0;
`endif

  // rst_n gates go so the PC register sees no enable while reset is held
  assign w_go = rst_n && (r_state == S_RUN || r_state == S_STEP) &&
                !(r_state == S_RUN && sys_halt);

  always_comb begin
    pc_en  = w_go && !w_bp && (exc || br_taken || !stall);
    pc_ld  = 1'b0;
    flush  = 1'b0;
    pc_new = '0;
    if (exc) begin
      pc_new = EXC_VECTOR;
      pc_ld  = 1'b1;
      flush  = 1'b1;
    end else if (br_taken) begin
      pc_new = br_target;
      pc_ld  = 1'b1;
      flush  = 1'b1;
    end else if (jmp) begin
      pc_new = jmp_target;
      pc_ld  = 1'b1;
    end
    if (!pc_en) begin
      pc_ld = 1'b0;
      flush = 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN:  if (sys_halt || halt_req || w_bp) w_next = S_HALT;
      S_HALT: if (halt_req)      w_next = S_HALT;
              else if (run_req)  w_next = S_RUN;
              else if (step_req) w_next = S_STEP;
      S_STEP: if (halt_req || pc_en) w_next = S_HALT;
      default: w_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
      adv_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (pc_en) adv_cnt <= adv_cnt + 32'd1;
    end
  end

`ifdef PC_SEQUENCER_BREAKPOINT_EN
  // skip lets the breakpointed instruction execute once after resuming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                        r_skip <= 1'b0;
    else if (r_state == S_HALT && (w_next == S_RUN || w_next == S_STEP)) r_skip <= 1'b1;
    else if (pc_en)                                                    r_skip <= 1'b0;
  end
`endif

  assign running = (r_state == S_RUN);
  assign halted  = (r_state == S_HALT);

endmodule
